// File: rtl/instr_sequencer_if.sv
// ============================================================================
// Module      : instr_sequencer_if
// Description : Control bundle between the instruction source and the
//               sequencer. Optional macro: RETIRE_CNT_EN adds 'retired'.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface instr_sequencer_if #(
   parameter int DATA_W = 16,
   parameter int RN_W   = 3
);
   logic              s;
   logic              load_ir;
   logic [15:0]       instr_in;
   logic              w;
   logic [RN_W-1:0]   readnum;
   logic [RN_W-1:0]   writenum;
   logic              write;
   logic              loada;
   logic              loadb;
   logic              loadc;
   logic              loads;
   logic              asel;
   logic              bsel;
   logic [1:0]        vsel;
   logic [1:0]        shift;
   logic [1:0]        alu_op;
   logic [DATA_W-1:0] sximm8;
   logic [DATA_W-1:0] sximm5;
   logic              illegal;
`ifdef RETIRE_CNT_EN
   logic [15:0]       retired;

   modport master (
      output s, load_ir, instr_in,
      input  w, readnum, writenum, write, loada, loadb, loadc, loads,
             asel, bsel, vsel, shift, alu_op, sximm8, sximm5, illegal, retired
   );

   modport slave (
      input  s, load_ir, instr_in,
      output w, readnum, writenum, write, loada, loadb, loadc, loads,
             asel, bsel, vsel, shift, alu_op, sximm8, sximm5, illegal, retired
   );
`else
   modport master (
      output s, load_ir, instr_in,
      input  w, readnum, writenum, write, loada, loadb, loadc, loads,
             asel, bsel, vsel, shift, alu_op, sximm8, sximm5, illegal
   );

   modport slave (
      input  s, load_ir, instr_in,
      output w, readnum, writenum, write, loada, loadb, loadc, loads,
             asel, bsel, vsel, shift, alu_op, sximm8, sximm5, illegal
   );
`endif
endinterface

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ============================================================================
// Module      : instr_sequencer
// Description : Instruction register, decoder and Moore micro-step FSM driving
//               the register file and datapath strobes.
//               Optional macro: RETIRE_CNT_EN adds the retired-instruction count.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module instr_sequencer #(
   parameter int DATA_W = 16,
   parameter int RN_W   = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   instr_sequencer_if.slave    bus
);

   typedef enum logic [2:0] {
      S_WAIT   = 3'd0,
      S_DECODE = 3'd1,
      S_GET_A  = 3'd2,
      S_GET_B  = 3'd3,
      S_ALU    = 3'd4,
      S_WR_REG = 3'd5,
      S_WR_IMM = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic        illegal_q, illegal_d;

   logic [2:0]  opcode;
   logic [1:0]  op;
   logic [2:0]  rn, rd, rm;
   logic        is_cmp;
   logic        is_zero_a;

   logic            w;
   logic [RN_W-1:0] readnum, writenum;
   logic            write, loada, loadb, loadc, loads, asel, bsel;
   logic [1:0]      vsel;

   assign opcode    = ir_q[15:13];
   assign op        = ir_q[12:11];
   assign rn        = ir_q[10:8];
   assign rd        = ir_q[7:5];
   assign rm        = ir_q[2:0];
   assign is_cmp    = ({opcode, op} == 5'b101_01);
   // MOV-reg and MVN pass only the B operand, so the A side is forced to zero
   assign is_zero_a = ({opcode, op} == 5'b110_00) || ({opcode, op} == 5'b101_11);

   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      illegal_d = illegal_q;
      w         = 1'b0;
      readnum   = '0;
      writenum  = '0;
      write     = 1'b0;
      loada     = 1'b0;
      loadb     = 1'b0;
      loadc     = 1'b0;
      loads     = 1'b0;
      asel      = 1'b0;
      bsel      = 1'b0;
      vsel      = 2'b00;

      case (state_q)
         S_WAIT: begin
            w = 1'b1;
            if (bus.load_ir) ir_d = bus.instr_in;
            if (bus.s)       state_d = S_DECODE;
         end
         S_DECODE: begin
            case ({opcode, op})
               5'b110_10: state_d = S_WR_IMM;
               5'b110_00: state_d = S_GET_B;
               5'b101_00,
               5'b101_01,
               5'b101_10: state_d = S_GET_A;
               5'b101_11: state_d = S_GET_B;
               default: begin
                  state_d   = S_WAIT;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_GET_A: begin
            readnum = RN_W'(rn);
            loada   = 1'b1;
            state_d = S_GET_B;
         end
         S_GET_B: begin
            readnum = RN_W'(rm);
            loadb   = 1'b1;
            state_d = S_ALU;
         end
         S_ALU: begin
            loadc   = ~is_cmp;
            loads   = is_cmp;
            asel    = is_zero_a;
            state_d = is_cmp ? S_WAIT : S_WR_REG;
         end
         S_WR_REG: begin
            writenum = RN_W'(rd);
            vsel     = 2'b00;
            write    = 1'b1;
            state_d  = S_WAIT;
         end
         S_WR_IMM: begin
            writenum = RN_W'(rn);
            vsel     = 2'b01;
            write    = 1'b1;
            state_d  = S_WAIT;
         end
         default: state_d = S_WAIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_WAIT;
         ir_q      <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         illegal_q <= illegal_d;
      end
   end

`ifdef RETIRE_CNT_EN
   logic [15:0] retired_q, retired_d;

   // Only completions that reach WAIT through a real micro-step count
   always_comb begin
      retired_d = retired_q;
      if ((state_q == S_WR_REG) || (state_q == S_WR_IMM) ||
          ((state_q == S_ALU) && is_cmp))
         retired_d = retired_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) retired_q <= '0;
      else        retired_q <= retired_d;
   end

   assign bus.retired = retired_q;
`endif

   assign bus.w        = w;
   assign bus.readnum  = readnum;
   assign bus.writenum = writenum;
   assign bus.write    = write;
   assign bus.loada    = loada;
   assign bus.loadb    = loadb;
   assign bus.loadc    = loadc;
   assign bus.loads    = loads;
   assign bus.asel     = asel;
   assign bus.bsel     = bsel;
   assign bus.vsel     = vsel;
   assign bus.shift    = ir_q[4:3];
   assign bus.alu_op   = ir_q[12:11];
   assign bus.sximm8   = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
   assign bus.sximm5   = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};
   assign bus.illegal  = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Scoreboard bench for instr_sequencer: instruction-level model
//               predicts strobe events and completion latency per instruction.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   instr_sequencer_if #(.DATA_W(16), .RN_W(3)) bus ();

   instr_sequencer #(.DATA_W(16), .RN_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [2:0]  readnum;
      logic [2:0]  writenum;
      logic        write;
      logic        loada;
      logic        loadb;
      logic        loadc;
      logic        loads;
      logic        asel;
      logic        bsel;
      logic [1:0]  vsel;
      logic [15:0] sx8;
      logic [1:0]  shift;
      logic [1:0]  aluop;
   } ev_t;

   typedef struct {
      int          lat;
      logic        ill;
      logic [15:0] ret;
   } done_t;

   ev_t   exp_ev[$];
   done_t exp_done[$];
   int    checks = 0;
   int    errors = 0;
   logic  mon_en = 1'b0;
   logic  ill_m = 1'b0;
   logic [15:0] ret_m = '0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] sx8f(logic [15:0] v);
      return {{8{v[7]}}, v[7:0]};
   endfunction

   function automatic logic [15:0] sx5f(logic [15:0] v);
      return {{11{v[4]}}, v[4:0]};
   endfunction

   // Instruction semantics: which registers are read, what is computed, what is written
   task automatic model(logic [15:0] ins);
      ev_t   e;
      done_t d;
      logic  legal = 1'b1;
      logic [2:0] rn = ins[10:8];
      logic [2:0] rd = ins[7:5];
      logic [2:0] rm = ins[2:0];
      logic [4:0] key = ins[15:11];
      logic  rd_a = (key == 5'b10100) || (key == 5'b10101) || (key == 5'b10110);
      logic  rd_b = rd_a || (key == 5'b11000) || (key == 5'b10111);
      if (key == 5'b11010) begin
         e = '0; e.writenum = rn; e.write = 1'b1; e.vsel = 2'b01; e.sx8 = sx8f(ins);
         exp_ev.push_back(e);
         d.lat = 2;
      end else if (rd_b) begin
         if (rd_a) begin
            e = '0; e.readnum = rn; e.loada = 1'b1; exp_ev.push_back(e);
         end
         e = '0; e.readnum = rm; e.loadb = 1'b1; exp_ev.push_back(e);
         e = '0; e.shift = ins[4:3]; e.aluop = ins[12:11];
         e.asel = !rd_a;
         if (key == 5'b10101) e.loads = 1'b1; else e.loadc = 1'b1;
         exp_ev.push_back(e);
         if (key != 5'b10101) begin
            e = '0; e.writenum = rd; e.write = 1'b1; e.vsel = 2'b00; exp_ev.push_back(e);
         end
         d.lat = (rd_a ? 2 : 1) + 2 + ((key == 5'b10101) ? 0 : 1);
      end else begin
         legal = 1'b0;
         ill_m = 1'b1;
         d.lat = 1;
      end
      if (legal) ret_m = ret_m + 16'd1;
      d.ill = ill_m;
      d.ret = ret_m;
      exp_done.push_back(d);
   endtask

   ev_t   obs, expv;
   done_t dn;
   logic  act;
   int    busy = 0;

   always @(negedge clk) begin
      if (!mon_en) begin
         busy = 0;
      end else begin
         obs          = '0;
         obs.readnum  = bus.readnum;
         obs.writenum = bus.writenum;
         obs.write    = bus.write;
         obs.loada    = bus.loada;
         obs.loadb    = bus.loadb;
         obs.loadc    = bus.loadc;
         obs.loads    = bus.loads;
         obs.asel     = bus.asel;
         obs.bsel     = bus.bsel;
         obs.vsel     = bus.vsel;
         if (bus.write && bus.vsel == 2'b01) obs.sx8 = bus.sximm8;
         if (bus.loadc || bus.loads) begin
            obs.shift = bus.shift;
            obs.aluop = bus.alu_op;
         end
         act = bus.write | bus.loada | bus.loadb | bus.loadc | bus.loads;
         if (act) begin
            checks++;
            if (exp_ev.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: got %h expected none", obs);
            end else begin
               expv = exp_ev.pop_front();
               if (obs !== expv) begin
                  errors++;
                  $display("FAIL event: got %h expected %h", obs, expv);
               end
            end
         end else begin
            chk("idle_outputs", 32'({bus.readnum, bus.writenum, bus.asel, bus.bsel, bus.vsel}), 32'd0);
         end
         if (!bus.w) begin
            busy++;
         end else if (busy > 0) begin
            if (exp_done.size() == 0) begin
               chk("unexpected_completion", 32'(busy), 32'd0);
            end else begin
               dn = exp_done.pop_front();
               chk("latency", 32'(busy), 32'(dn.lat));
               chk("illegal", 32'(bus.illegal), 32'(dn.ill));
`ifdef RETIRE_CNT_EN
               chk("retired", 32'(bus.retired), 32'(dn.ret));
`endif
            end
            busy = 0;
         end
      end
   end

   task automatic wait_idle();
      for (int n = 0; n < 40; n++) begin
         if (bus.w === 1'b1) break;
         @(negedge clk);
      end
      if (bus.w !== 1'b1) chk("idle_timeout", 32'(bus.w), 32'd1);
   endtask

   task automatic issue(logic [15:0] ins, bit together, bit noise);
      wait_idle();
      model(ins);
      bus.instr_in = ins;
      bus.load_ir  = 1'b1;
      if (together) begin
         bus.s = 1'b1;
         @(negedge clk);
         bus.load_ir = 1'b0;
         bus.s       = 1'b0;
      end else begin
         @(negedge clk);
         bus.load_ir = 1'b0;
         bus.s       = 1'b1;
         @(negedge clk);
         bus.s       = 1'b0;
      end
      // Load attempts while busy must not disturb the instruction in flight
      for (int n = 0; n < 40; n++) begin
         bus.load_ir = 1'b0;
         if (bus.w) break;
         if (noise && ($urandom_range(0, 1) == 1)) begin
            bus.load_ir  = 1'b1;
            bus.instr_in = 16'($urandom);
         end
         @(negedge clk);
      end
      bus.load_ir = 1'b0;
   endtask

   task automatic issue_hold(logic [15:0] ins);
      wait_idle();
      model(ins);
      model(ins);
      bus.instr_in = ins;
      bus.load_ir  = 1'b1;
      bus.s        = 1'b1;
      @(negedge clk);
      bus.load_ir = 1'b0;
      for (int n = 0; n < 40 && !bus.w; n++) @(negedge clk);
      @(negedge clk);
      for (int n = 0; n < 40 && !bus.w; n++) @(negedge clk);
      bus.s = 1'b0;
   endtask

   function automatic logic [15:0] rand_instr();
      logic [15:0] r = 16'($urandom);
      case ($urandom_range(0, 6))
         0: r[15:11] = 5'b11010;
         1: r[15:11] = 5'b11000;
         2: r[15:11] = 5'b10100;
         3: r[15:11] = 5'b10101;
         4: r[15:11] = 5'b10110;
         5: r[15:11] = 5'b10111;
         default: ;
      endcase
      return r;
   endfunction

   logic [15:0] probe;
   logic        saw_write;

   initial begin
      bus.s        = 1'b0;
      bus.load_ir  = 1'b0;
      bus.instr_in = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("reset_w", 32'(bus.w), 32'd1);
      chk("reset_strobes", 32'({bus.write, bus.loada, bus.loadb, bus.loadc,
                                bus.loads, bus.asel, bus.bsel, bus.vsel}), 32'd0);
      chk("reset_nums", 32'({bus.readnum, bus.writenum}), 32'd0);
      chk("reset_illegal", 32'(bus.illegal), 32'd0);
      chk("reset_ir", 32'(bus.sximm8), 32'd0);
`ifdef RETIRE_CNT_EN
      chk("reset_retired", 32'(bus.retired), 32'd0);
`endif

      probe        = 16'h1234;
      bus.instr_in = probe;
      bus.load_ir  = 1'b1;
      @(negedge clk);
      bus.load_ir = 1'b0;
      chk("load_only_sximm8", 32'(bus.sximm8), 32'(sx8f(probe)));
      chk("load_only_sximm5", 32'(bus.sximm5), 32'(sx5f(probe)));
      chk("load_only_fields", 32'({bus.shift, bus.alu_op}), 32'({probe[4:3], probe[12:11]}));
      @(negedge clk);
      chk("load_only_stays_wait", 32'(bus.w), 32'd1);

      mon_en = 1'b1;
      issue(16'hD2F6, 1'b1, 1'b0);
      issue(16'hA16A, 1'b1, 1'b0);
      issue(16'hA900, 1'b0, 1'b0);
      issue(16'hE000, 1'b1, 1'b0);
      issue(16'hA16A, 1'b0, 1'b1);
      issue(16'hB864, 1'b1, 1'b1);
      issue_hold(16'hB0A1);
      repeat (120) issue(rand_instr(), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      wait_idle();
      repeat (3) @(negedge clk);
      chk("drain_events", 32'(exp_ev.size()), 32'd0);
      chk("drain_done", 32'(exp_done.size()), 32'd0);

      // Asynchronous reset while the MVN sits in its ALU step
      mon_en       = 1'b0;
      bus.instr_in = 16'hB864;
      bus.load_ir  = 1'b1;
      bus.s        = 1'b1;
      @(negedge clk);
      bus.load_ir = 1'b0;
      bus.s       = 1'b0;
      repeat (2) @(negedge clk);
      chk("mvn_alu_step", 32'({bus.loadc, bus.asel, bus.w}), 32'b110);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_w", 32'(bus.w), 32'd1);
      chk("async_reset_write", 32'({bus.write, bus.loadc}), 32'd0);
      chk("async_reset_illegal", 32'(bus.illegal), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_write = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.write || !bus.w) saw_write = 1'b1;
      end
      chk("dropped_write", 32'(saw_write), 32'd0);
`ifdef RETIRE_CNT_EN
      chk("retired_after_reset", 32'(bus.retired), 32'd0);
`endif

      ill_m  = 1'b0;
      ret_m  = '0;
      mon_en = 1'b1;
      issue(16'hD105, 1'b1, 1'b0);
      issue(16'hD0FF, 1'b0, 1'b0);
      wait_idle();
      repeat (2) @(negedge clk);
      chk("final_events", 32'(exp_ev.size() + exp_done.size()), 32'd0);
`ifdef RETIRE_CNT_EN
      chk("retired_two_movs", 32'(bus.retired), 32'd2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
